// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the memory controller port
// between the fetch unit and the load/store unit.
module mem_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [1:0]        ls_mode,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mc_addr,
  output logic              mc_we,
  output logic [31:0]       mc_wdata,
  output logic [1:0]        mc_mode,
  output logic              mc_enable,
  input  logic [31:0]       mc_rdata,
  input  logic              mc_op_r
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic        owner;
  logic        last_owner;
  logic        win;
  logic        win_ls;
  logic        tmo;
  logic        fin;
  logic [7:0]  cnt;
  logic [31:0] rd_val;
  logic [1:0]  ls_mode_fw;

  assign tmo        = (cnt == TO_LAST);
  assign fin        = (state == WAIT) && (mc_op_r || tmo);
  assign rd_val     = (mc_op_r && !mc_we) ? mc_rdata : 32'h0;
  assign ls_mode_fw = (ls_mode == 2'b11) ? 2'b00 : ls_mode;

  assign mc_enable = (state == ISSUE);
  assign if_gnt    = (state == ISSUE) && !owner;
  assign ls_gnt    = (state == ISSUE) && owner;
  assign if_rvalid = (state == RESP) && !owner;
  assign ls_rvalid = (state == RESP) && owner;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and round-robin arbitration
  always_comb begin
    state_nx = state;
    win      = 1'b0;
    win_ls   = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        state_nx = IDLE;
        if (if_req || ls_req) begin
          win      = 1'b1;
          win_ls   = ls_req && (!if_req || !last_owner);
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT:  if (mc_op_r || tmo) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // latched request fields, owner tracking and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_owner <= 1'b0;
      mc_addr    <= '0;
      mc_we      <= 1'b0;
      mc_wdata   <= '0;
      mc_mode    <= '0;
      cnt        <= '0;
    end else begin
      if (win) begin
        owner      <= win_ls;
        last_owner <= win_ls;
        mc_addr    <= win_ls ? ls_addr : if_addr;
        mc_we      <= win_ls && ls_we;
        mc_wdata   <= win_ls ? ls_wdata : 32'h0;
        mc_mode    <= win_ls ? ls_mode_fw : 2'b00;
      end else if (state_nx == IDLE) begin
        mc_we <= 1'b0;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 8'd1;
    end
  end

  // per-requester response data, untouched for the non-owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      if_err   <= 1'b0;
      ls_rdata <= '0;
      ls_err   <= 1'b0;
    end else if (fin) begin
      if (owner) begin
        ls_rdata <= rd_val;
        ls_err   <= !mc_op_r;
      end else begin
        if_rdata <= rd_val;
        if_err   <= !mc_op_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter
// with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [23:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [23:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [1:0]  ls_mode;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic [23:0] mc_addr;
  logic        mc_we;
  logic [31:0] mc_wdata;
  logic [1:0]  mc_mode;
  logic        mc_enable;
  logic [31:0] mc_rdata;
  logic        mc_op_r;

  int n_run  = 0;
  int n_fail = 0;
  int n_ig = 0, n_lg = 0, n_en = 0;
  int n_ir = 0, n_lr = 0;

  mem_port_arbiter #(.ADDR_W(24), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_mode(ls_mode), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err), .mc_addr(mc_addr),
    .mc_we(mc_we), .mc_wdata(mc_wdata),
    .mc_mode(mc_mode), .mc_enable(mc_enable),
    .mc_rdata(mc_rdata), .mc_op_r(mc_op_r)
  );

  always #5 clk = ~clk;

  // pulse counters
  always @(posedge clk) begin
    if (if_gnt)    n_ig++;
    if (ls_gnt)    n_lg++;
    if (mc_enable) n_en++;
    if (if_rvalid) n_ir++;
    if (ls_rvalid) n_lr++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int b_ig, b_lg, b_en, b_ir, b_lr, rv;

  initial begin
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    ls_mode  = '0;
    mc_rdata = '0;
    mc_op_r  = 1'b0;
    repeat (2) step();
    check("rst_enable", 32'(mc_enable), 32'd0);
    check("rst_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    check("rst_mc_addr", 32'(mc_addr), 32'd0);
    rst_n = 1'b1;
    step();

    // single fetch
    b_ig = n_ig; b_en = n_en; b_ir = n_ir;
    if_req = 1'b1; if_addr = 24'h000004;
    step();
    check("f_gnt", 32'(if_gnt), 32'd1);
    check("f_en", 32'(mc_enable), 32'd1);
    check("f_mode", 32'(mc_mode), 32'd0);
    check("f_we", 32'(mc_we), 32'd0);
    check("f_addr", 32'(mc_addr), 32'h4);
    if_req = 1'b0;
    step();
    mc_rdata = 32'h01009303; mc_op_r = 1'b1;
    step();
    mc_op_r = 1'b0;
    check("f_rvalid", 32'(if_rvalid), 32'd1);
    check("f_rdata", if_rdata, 32'h01009303);
    check("f_err", 32'(if_err), 32'd0);
    step();
    check("f_idle_rv", 32'(if_rvalid), 32'd0);
    check("f_n_gnt", 32'(n_ig - b_ig), 32'd1);
    check("f_n_en", 32'(n_en - b_en), 32'd1);
    check("f_n_rv", 32'(n_ir - b_ir), 32'd1);

    // byte store
    ls_req = 1'b1; ls_we = 1'b1; ls_mode = 2'b01;
    ls_addr = 24'h000010; ls_wdata = 32'h000000AB;
    step();
    check("s_gnt", 32'(ls_gnt), 32'd1);
    check("s_we", 32'(mc_we), 32'd1);
    check("s_mode", 32'(mc_mode), 32'd1);
    check("s_wdata", mc_wdata, 32'hAB);
    check("s_addr", 32'(mc_addr), 32'h10);
    ls_req = 1'b0;
    step();
    mc_rdata = 32'hDEADBEEF; mc_op_r = 1'b1;
    step();
    mc_op_r = 1'b0;
    check("s_rvalid", 32'(ls_rvalid), 32'd1);
    check("s_rdata", ls_rdata, 32'd0);
    check("s_err", 32'(ls_err), 32'd0);
    check("s_we_resp", 32'(mc_we), 32'd1);
    check("s_if_keep", if_rdata, 32'h01009303);
    check("s_if_rv", 32'(if_rvalid), 32'd0);
    step();
    check("s_we_idle", 32'(mc_we), 32'd0);

    // continuous contention after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ls_we = 1'b0; ls_mode = 2'b11; ls_addr = 24'h000020;
    if_addr = 24'h000008;
    if_req = 1'b1; ls_req = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      automatic logic lsw = (i % 2 == 0);
      check($sformatf("rr%0d_ls_gnt", i), 32'(ls_gnt), 32'(lsw));
      check($sformatf("rr%0d_if_gnt", i), 32'(if_gnt), 32'(!lsw));
      if (lsw) check($sformatf("rr%0d_mode", i), 32'(mc_mode), 32'd0);
      step();
      mc_rdata = 32'h100 + 32'(i); mc_op_r = 1'b1;
      step();
      mc_op_r = 1'b0;
      if (lsw) begin
        check($sformatf("rr%0d_rv", i), 32'(ls_rvalid), 32'd1);
        check($sformatf("rr%0d_rd", i), ls_rdata, 32'h100 + 32'(i));
      end else begin
        check($sformatf("rr%0d_rv", i), 32'(if_rvalid), 32'd1);
        check($sformatf("rr%0d_rd", i), if_rdata, 32'h100 + 32'(i));
      end
      step();
      check($sformatf("rr%0d_nogap", i), 32'(mc_enable), 32'd1);
    end
    if_req = 1'b0; ls_req = 1'b0;
    step();
    mc_op_r = 1'b1;
    step();
    mc_op_r = 1'b0;
    step();

    // timeout on a load
    b_lr = n_lr;
    ls_req = 1'b1; ls_mode = 2'b00; ls_addr = 24'h000030;
    mc_rdata = 32'hCAFEF00D;
    step();
    check("t_gnt", 32'(ls_gnt), 32'd1);
    ls_req = 1'b0;
    rv = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (ls_rvalid) rv++;
    end
    check("t_early_rv", 32'(rv), 32'd0);
    step();
    check("t_rvalid", 32'(ls_rvalid), 32'd1);
    check("t_err", 32'(ls_err), 32'd1);
    check("t_rdata", ls_rdata, 32'd0);
    step();
    if_req = 1'b1; if_addr = 24'h000040;
    step();
    check("t2_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    step();
    mc_rdata = 32'h00000013; mc_op_r = 1'b1;
    step();
    mc_op_r = 1'b0;
    check("t2_rv", 32'(if_rvalid), 32'd1);
    check("t2_rd", if_rdata, 32'h13);
    check("t2_err", 32'(if_err), 32'd0);
    step();

    // reset while waiting
    if_req = 1'b1; if_addr = 24'h000050;
    step();
    if_req = 1'b0;
    step();
    b_ir = n_ir; b_lr = n_lr;
    rst_n = 1'b0;
    #1;
    check("r_en", 32'(mc_enable), 32'd0);
    check("r_addr", 32'(mc_addr), 32'd0);
    check("r_if_rdata", if_rdata, 32'd0);
    check("r_rv", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    mc_op_r = 1'b1;
    repeat (2) step();
    mc_op_r = 1'b0;
    rst_n = 1'b1;
    step();
    check("r_no_rv", 32'((n_ir - b_ir) + (n_lr - b_lr)), 32'd0);
    if_req = 1'b1; if_addr = 24'h000060;
    step();
    check("r_f_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    step();
    mc_rdata = 32'h00A00093; mc_op_r = 1'b1;
    step();
    mc_op_r = 1'b0;
    check("r_f_rd", if_rdata, 32'h00A00093);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    if_req = 1'b1; ls_req = 1'b1;
    step();
    check("r_tie_ls", 32'(ls_gnt), 32'd1);
    if_req = 1'b0; ls_req = 1'b0;
    step();
    mc_op_r = 1'b1;
    step();
    mc_op_r = 1'b0;
    step();

    // spurious ready in IDLE and ISSUE
    b_ir = n_ir;
    mc_op_r = 1'b1; mc_rdata = 32'h11111111;
    step();
    check("sp_idle", 32'(n_ir - b_ir), 32'd0);
    if_req = 1'b1; if_addr = 24'h000070;
    step();
    check("sp_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    step();
    check("sp_issue", 32'(if_rvalid), 32'd0);
    mc_op_r = 1'b0;
    step();
    check("sp_wait", 32'(if_rvalid), 32'd0);
    mc_op_r = 1'b1; mc_rdata = 32'h22222222;
    step();
    mc_op_r = 1'b0;
    check("sp_rv", 32'(if_rvalid), 32'd1);
    check("sp_rd", if_rdata, 32'h22222222);
    step();
    check("sp_n_rv", 32'(n_ir - b_ir), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
